// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver running on the system clock with an internal bit-period
//   counter. The serial input is brought in through a two-flop synchronizer;
//   every decision is taken on the synchronized copy (r_rx_s).
//
//   Timing origin T0 is the first clock edge in IDLE at which r_rx_s is low.
//   The start bit is re-checked at T0+HALF_BIT, and each later bit is sampled
//   one full CLKS_PER_BIT after the previous sample. The bit counter is cleared
//   at every sample point, so sample positions do not drift cumulatively.
//
//   Optional feature (macro UART_RX_PARITY_EN): an even-parity bit follows
//   data bit 7. A parity mismatch is reported as o_frame_err after the stop
//   sample, and o_valid is suppressed for that frame.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (legal range 4..65535)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_rx         serial line, idle high, asynchronous to i_clk
//   o_data       last correctly received byte (LSB first on the wire)
//   o_valid      one-cycle strobe, o_data was updated with a good frame
//   o_busy       high whenever the FSM is outside IDLE
//   o_frame_err  one-cycle strobe, bad stop bit (or bad parity)
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // The counter reads k-1 at the k-th edge after it was cleared, hence the -1.
  localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             w_par_ok;
  logic             w_cnt_full;

`ifdef UART_RX_PARITY_EN
  logic             r_par;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_ok = ~(^{r_shift, r_par});
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_cnt_full = (r_cnt == C_FULL_M1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_s      <= r_rx_meta;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end

        S_START: begin
          if (r_cnt == C_HALF_M1) begin
            r_cnt <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_cnt_full) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_cnt_full) begin
            r_cnt   <= '0;
            r_par   <= r_rx_s;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_cnt_full) begin
            r_cnt <= '0;
            if (r_rx_s && w_par_ok) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              // A low stop bit means the line may be held in break; wait it
              // out so it cannot be mistaken for a new start bit.
              r_state     <= r_rx_s ? S_IDLE : S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule
